ahb_arbiter: RTL and testbench
==============================

AHB_ARBITER -- requirements
Module: ahb_arbiter

Interface
REQ-001 SHALL have parameter NM, default 4: number of masters, fixed range 2..4.
REQ-002 SHALL have parameter DEFAULT_MASTER, default 0: master granted when no request is pending.
REQ-003 SHALL use one clock and an asynchronous, active-low reset.
REQ-004 SHALL have port CLK  in  1: clock, rising edge active.
REQ-005 SHALL have port HRESETn  in  1: asynchronous active-low reset.
REQ-006 SHALL have port HBUSREQ  in  NM: per-master bus request.
REQ-007 SHALL have port HLOCK  in  NM: per-master locked-access request.
REQ-008 SHALL have port HTRANS  in  2: muxed transfer type (IDLE/BUSY/NONSEQ/SEQ).
REQ-009 SHALL have port HBURST  in  3: muxed burst type.
REQ-010 SHALL have port HREADY  in  1: transfer-complete from slave mux.
REQ-011 SHALL have port HRESP  in  2: slave response (OKAY/ERROR/RETRY/SPLIT).
REQ-012 SHALL have port HSPLIT  in  NM: split-resume pulses; present only under AHB_ARB_SPLIT_EN.
REQ-013 SHALL have port HGRANT  out  NM: registered one-hot grant.
REQ-014 SHALL have port HMASTER  out  2: registered owner of the current address phase.
REQ-015 SHALL have port HMASTLOCK  out  1: registered lock indication for the current address phase.

Function
REQ-016 SHALL implement states GRANT_DEFAULT (no owner), OWNED (burst in progress), LOCKED (owner holds HLOCK).
REQ-017 SHALL re-arbitrate only on a rising edge with HREADY=1 at an arbitration point.
- Arbitration points: HTRANS=IDLE; last beat of SINGLE/INCR4/WRAP4 (1/4), INCR8/WRAP8 (8), INCR16/WRAP16 (16); INCR with owner HBUSREQ=0.
REQ-018 SHALL count beats with a 4-bit counter.
- Load on NONSEQ with HREADY=1.
- Increment on SEQ with HREADY=1.
- Hold on BUSY or HREADY=0.
REQ-019 SHALL pick by round-robin among requesting, unmasked masters, starting at (last owner+1) mod NM.
REQ-020 SHALL grant DEFAULT_MASTER and enter GRANT_DEFAULT when no eligible request exists.
REQ-021 SHALL update HGRANT one cycle after the arbitration point (registered; latency 1).
REQ-022 SHALL load HMASTER and HMASTLOCK from HGRANT and the granted HLOCK only on edges with HREADY=1.
- HMASTER therefore trails HGRANT by one HREADY-qualified cycle.
REQ-023 SHALL enter LOCKED when the granted master has HLOCK=1 at NONSEQ.
- No re-arbitration in LOCKED until HLOCK drops and an arbitration point completes.
- Ownership is then held one further cycle.
REQ-024 SHALL keep the current grant on HRESP=RETRY and HRESP=ERROR; the owner re-issues the transfer.
REQ-025 SHALL keep HGRANT and counters unchanged while HREADY=0 (wait states).
REQ-026 SHALL allow a single requester that is also owner to retain the grant across back-to-back bursts without a gap cycle.
REQ-027 SHALL resolve HBUSREQ deasserted mid defined-length burst by completing the burst before re-arbitrating.

Reset
REQ-028 SHALL on HRESETn=0 set, asynchronously: HGRANT=one-hot(DEFAULT_MASTER), HMASTER=DEFAULT_MASTER, HMASTLOCK=0, state GRANT_DEFAULT, beat counter 0, round-robin pointer DEFAULT_MASTER, split mask 0.
REQ-029 SHALL discard any in-progress burst or lock on reset mid-operation; no state is retained.

Configuration
REQ-030 SHALL compile split support when macro AHB_ARB_SPLIT_EN is defined.
- HRESP=SPLIT with HREADY=1 sets the owner's mask bit and forces re-arbitration on that edge.
- HSPLIT[i]=1 clears mask bit i.
- A same-cycle set and clear for one master resolves as clear.
- Masked masters are ineligible.
REQ-031 SHALL, without AHB_ARB_SPLIT_EN, omit port HSPLIT and the mask, and treat SPLIT exactly as RETRY.

Structure
REQ-032 SHALL take HTRANS/HBURST/HRESP encodings from the shared AHB define include.
REQ-033 SHALL place the arbiter state enum and the burst-length lookup constants in package ahb_arb_pkg.
REQ-034 SHALL implement round-robin selection in combinational sub-module ahb_arb_rr_pick (inputs request, mask, pointer; output one-hot).

Verification
REQ-035 Reset: HRESETn=0 with CLK running -> HGRANT=4'b0001, HMASTER=0, HMASTLOCK=0.
REQ-036 Round-robin: HBUSREQ=4'b0110, SINGLE transfers, HREADY=1 -> grants alternate 4'b0010, 4'b0100, 4'b0010.
REQ-037 Burst hold: master 2 INCR8 while master 3 requests -> HGRANT stays 4'b0100 for 8 beats; then 4'b1000 at the next edge.
REQ-038 Wait states: HREADY=0 for 3 cycles on beat 4 of an INCR4 -> HGRANT and HMASTER unchanged until HREADY=1.
REQ-039 Lock: master 1 HLOCK=1 over two INCR4 bursts, master 0 requesting -> master 0 not granted until HLOCK drops plus one cycle; HMASTLOCK=1 throughout.
REQ-040 Split (AHB_ARB_SPLIT_EN): HRESP=SPLIT for master 3 -> master 3 masked and never granted; HSPLIT=4'b1000 pulse -> master 3 is granted again.

Source files
------------

// File: rtl/ahb_arb_pkg.sv
// Arbiter state enum, AHB constants and burst-length lookup.
// Shared by ahb_arbiter and ahb_arb_rr_pick.
`include "ahb_defs.sv"

package ahb_arb_pkg;

  typedef enum logic [1:0] {
    GRANT_DEFAULT = 2'd0,
    OWNED         = 2'd1,
    LOCKED        = 2'd2
  } arb_state_e;

  localparam logic [1:0] TR_IDLE   = `AHB_HTRANS_IDLE;
  localparam logic [1:0] TR_BUSY   = `AHB_HTRANS_BUSY;
  localparam logic [1:0] TR_NONSEQ = `AHB_HTRANS_NONSEQ;
  localparam logic [1:0] TR_SEQ    = `AHB_HTRANS_SEQ;

  localparam logic [2:0] BU_SINGLE = `AHB_HBURST_SINGLE;
  localparam logic [2:0] BU_INCR   = `AHB_HBURST_INCR;
  localparam logic [2:0] BU_WRAP4  = `AHB_HBURST_WRAP4;
  localparam logic [2:0] BU_INCR4  = `AHB_HBURST_INCR4;
  localparam logic [2:0] BU_WRAP8  = `AHB_HBURST_WRAP8;
  localparam logic [2:0] BU_INCR8  = `AHB_HBURST_INCR8;
  localparam logic [2:0] BU_WRAP16 = `AHB_HBURST_WRAP16;
  localparam logic [2:0] BU_INCR16 = `AHB_HBURST_INCR16;

  localparam logic [1:0] RS_OKAY  = `AHB_HRESP_OKAY;
  localparam logic [1:0] RS_ERROR = `AHB_HRESP_ERROR;
  localparam logic [1:0] RS_RETRY = `AHB_HRESP_RETRY;
  localparam logic [1:0] RS_SPLIT = `AHB_HRESP_SPLIT;

  // Index of the final beat; INCR has no fixed end.
  function automatic logic [3:0] burst_last(
    input logic [2:0] hburst
  );
    logic [3:0] r;
    r = 4'd0;
    unique case (hburst)
      BU_SINGLE: r = 4'd0;
      BU_INCR:   r = 4'd0;
      BU_WRAP4:  r = 4'd3;
      BU_INCR4:  r = 4'd3;
      BU_WRAP8:  r = 4'd7;
      BU_INCR8:  r = 4'd7;
      BU_WRAP16: r = 4'd15;
      BU_INCR16: r = 4'd15;
    endcase
    return r;
  endfunction

  function automatic logic [1:0] oh2idx(
    input logic [3:0] oh
  );
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (oh[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/ahb_arb_rr_pick.sv
// Combinational round-robin pick: first eligible master
// after ptr_i, wrapping; all-zero output when none eligible.
module ahb_arb_rr_pick
  import ahb_arb_pkg::*;
#(
  parameter int NM = 4
) (
  input  logic [NM-1:0] req_i,
  input  logic [NM-1:0] mask_i,
  input  logic [1:0]    ptr_i,
  output logic [NM-1:0] gnt_o
);

  logic [NM-1:0] elig;

  assign elig = req_i & ~mask_i;

  // Walk distances far-to-near so the nearest hit wins.
  always_comb begin
    gnt_o = '0;
    for (int k = NM; k >= 1; k--) begin
      for (int i = 0; i < NM; i++) begin
        if (elig[i] && ((int'(ptr_i) + k) % NM) == i) begin
          gnt_o    = '0;
          gnt_o[i] = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/ahb_defs.sv
// AHB bus encodings shared by the arbiter and its neighbours.
// Include-guarded so it can be both compiled and included.
`ifndef AHB_DEFS_SV
`define AHB_DEFS_SV

`define AHB_HTRANS_IDLE   2'b00
`define AHB_HTRANS_BUSY   2'b01
`define AHB_HTRANS_NONSEQ 2'b10
`define AHB_HTRANS_SEQ    2'b11

`define AHB_HBURST_SINGLE 3'b000
`define AHB_HBURST_INCR   3'b001
`define AHB_HBURST_WRAP4  3'b010
`define AHB_HBURST_INCR4  3'b011
`define AHB_HBURST_WRAP8  3'b100
`define AHB_HBURST_INCR8  3'b101
`define AHB_HBURST_WRAP16 3'b110
`define AHB_HBURST_INCR16 3'b111

`define AHB_HRESP_OKAY    2'b00
`define AHB_HRESP_ERROR   2'b01
`define AHB_HRESP_RETRY   2'b10
`define AHB_HRESP_SPLIT   2'b11

`endif

// File: rtl/ahb_arbiter.sv
// AHB bus arbiter: round-robin, burst/lock aware, registered grant.
// Define AHB_ARB_SPLIT_EN to add HSPLIT and split masking.
module ahb_arbiter
  import ahb_arb_pkg::*;
#(
  parameter int NM             = 4,
  parameter int DEFAULT_MASTER = 0
) (
  input  logic          CLK,
  input  logic          HRESETn,
  input  logic [NM-1:0] HBUSREQ,
  input  logic [NM-1:0] HLOCK,
  input  logic [1:0]    HTRANS,
  input  logic [2:0]    HBURST,
  input  logic          HREADY,
  input  logic [1:0]    HRESP,
`ifdef AHB_ARB_SPLIT_EN
  input  logic [NM-1:0] HSPLIT,
`endif
  output logic [NM-1:0] HGRANT,
  output logic [1:0]    HMASTER,
  output logic          HMASTLOCK
);

  localparam logic [NM-1:0] DEF_OH =
    {{(NM-1){1'b0}}, 1'b1} << DEFAULT_MASTER;
  localparam logic [1:0] DEF_IDX = 2'(DEFAULT_MASTER);

  arb_state_e    state_q, state_d;
  logic [NM-1:0] grant_q, grant_d;
  logic [1:0]    ptr_q, ptr_d;
  logic [1:0]    master_q, master_d;
  logic          mlock_q, mlock_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          hold_q, hold_d;

  logic [1:0]    own_idx;
  logic          own_req;
  logic          own_lock;
  logic [3:0]    cur_beat;
  logic          xfer;
  logic          arb_pt;
  logic          rearb;
  logic          split_hit;
  logic          resp_hold;
  logic [NM-1:0] mask_d;
  logic [NM-1:0] pick_oh;

  assign own_idx  = oh2idx(4'(grant_q));
  assign own_req  = HBUSREQ[own_idx];
  assign own_lock = HLOCK[own_idx];

`ifdef AHB_ARB_SPLIT_EN
  logic [NM-1:0] mask_q;

  assign split_hit = HREADY && (HRESP == RS_SPLIT);
  assign resp_hold = (HRESP == RS_RETRY) ||
                     (HRESP == RS_ERROR);
  // Resume pulse beats a same-cycle split.
  assign mask_d = (mask_q | (split_hit ? grant_q : '0))
                & ~HSPLIT;

  always_ff @(posedge CLK or negedge HRESETn) begin
    if (!HRESETn) mask_q <= '0;
    else          mask_q <= mask_d;
  end
`else
  assign split_hit = 1'b0;
  assign resp_hold = (HRESP == RS_RETRY) ||
                     (HRESP == RS_ERROR) ||
                     (HRESP == RS_SPLIT);
  assign mask_d    = '0;
`endif

  ahb_arb_rr_pick #(
    .NM (NM)
  ) u_pick (
    .req_i  (HBUSREQ),
    .mask_i (mask_d),
    .ptr_i  (ptr_q),
    .gnt_o  (pick_oh)
  );

  // Beat index of the transfer in the current address phase.
  always_comb begin
    cur_beat = cnt_q;
    unique case (HTRANS)
      TR_NONSEQ: cur_beat = 4'd0;
      TR_SEQ:    cur_beat = cnt_q + 4'd1;
      default:   ;
    endcase
  end

  assign xfer   = (HTRANS == TR_NONSEQ) ||
                  (HTRANS == TR_SEQ);
  assign arb_pt = (HTRANS == TR_IDLE) ||
                  (HBURST == BU_INCR && HTRANS != TR_IDLE
                    && !own_req) ||
                  (HBURST != BU_INCR && xfer
                    && cur_beat == burst_last(HBURST));

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    ptr_d    = ptr_q;
    hold_d   = hold_q;
    cnt_d    = cnt_q;
    master_d = master_q;
    mlock_d  = mlock_q;
    rearb    = 1'b0;
    if (HREADY) begin
      cnt_d    = cur_beat;
      master_d = own_idx;
      mlock_d  = own_lock;
      if (split_hit) begin
        rearb = 1'b1;
      end else if (resp_hold) begin
        rearb = 1'b0;
      end else if (hold_q) begin
        rearb = 1'b1;
      end else if (state_q == LOCKED) begin
        // Lock released: keep the bus one more cycle.
        if (arb_pt && !own_lock) begin
          state_d = OWNED;
          hold_d  = 1'b1;
        end
      end else if (HTRANS == TR_NONSEQ && own_lock) begin
        state_d = LOCKED;
      end else if (arb_pt) begin
        rearb = 1'b1;
      end
      if (rearb) begin
        hold_d = 1'b0;
        if (|pick_oh) begin
          grant_d = pick_oh;
          ptr_d   = oh2idx(4'(pick_oh));
          state_d = OWNED;
        end else begin
          grant_d = DEF_OH;
          state_d = GRANT_DEFAULT;
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q  <= GRANT_DEFAULT;
      grant_q  <= DEF_OH;
      ptr_q    <= DEF_IDX;
      master_q <= DEF_IDX;
      mlock_q  <= 1'b0;
      cnt_q    <= 4'd0;
      hold_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      ptr_q    <= ptr_d;
      master_q <= master_d;
      mlock_q  <= mlock_d;
      cnt_q    <= cnt_d;
      hold_q   <= hold_d;
    end
  end

  assign HGRANT    = grant_q;
  assign HMASTER   = master_q;
  assign HMASTLOCK = mlock_q;

endmodule

// File: tb/tb_ahb_arbiter.sv
// Directed self-checking bench for ahb_arbiter (NM=4).
// Split scenario runs only when AHB_ARB_SPLIT_EN is defined.
module tb_ahb_arbiter;

  localparam logic [1:0] IDLE   = 2'b00;
  localparam logic [1:0] NONSEQ = 2'b10;
  localparam logic [1:0] SEQ    = 2'b11;
  localparam logic [2:0] SINGLE = 3'b000;
  localparam logic [2:0] INCR   = 3'b001;
  localparam logic [2:0] INCR4  = 3'b011;
  localparam logic [2:0] INCR8  = 3'b101;
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] ERROR  = 2'b01;
  localparam logic [1:0] RETRY  = 2'b10;
  localparam logic [1:0] SPLIT  = 2'b11;

  logic       CLK = 1'b0;
  logic       HRESETn;
  logic [3:0] HBUSREQ;
  logic [3:0] HLOCK;
  logic [1:0] HTRANS;
  logic [2:0] HBURST;
  logic       HREADY;
  logic [1:0] HRESP;
`ifdef AHB_ARB_SPLIT_EN
  logic [3:0] HSPLIT;
`endif
  logic [3:0] HGRANT;
  logic [1:0] HMASTER;
  logic       HMASTLOCK;

  int checks   = 0;
  int failures = 0;

  ahb_arbiter #(
    .NM             (4),
    .DEFAULT_MASTER (0)
  ) dut (
    .CLK       (CLK),
    .HRESETn   (HRESETn),
    .HBUSREQ   (HBUSREQ),
    .HLOCK     (HLOCK),
    .HTRANS    (HTRANS),
    .HBURST    (HBURST),
    .HREADY    (HREADY),
    .HRESP     (HRESP),
`ifdef AHB_ARB_SPLIT_EN
    .HSPLIT    (HSPLIT),
`endif
    .HGRANT    (HGRANT),
    .HMASTER   (HMASTER),
    .HMASTLOCK (HMASTLOCK)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    HRESETn = 1'b0;
    HBUSREQ = 4'b0000;
    HLOCK   = 4'b0000;
    HTRANS  = IDLE;
    HBURST  = SINGLE;
    HREADY  = 1'b1;
    HRESP   = OKAY;
`ifdef AHB_ARB_SPLIT_EN
    HSPLIT  = 4'b0000;
`endif
    repeat (3) tick();
    checks++;
    if (HGRANT !== 4'b0001) begin
      failures++;
      $display("FAIL reset_grant got=%b exp=0001", HGRANT);
    end
    checks++;
    if (HMASTER !== 2'd0) begin
      failures++;
      $display("FAIL reset_master got=%0d exp=0", HMASTER);
    end
    checks++;
    if (HMASTLOCK !== 1'b0) begin
      failures++;
      $display("FAIL reset_mlock got=%b exp=0", HMASTLOCK);
    end
    HRESETn = 1'b1;
    tick();
  endtask

  task automatic test_round_robin();
    logic [3:0] eg [3];
    logic [1:0] em [3];
    eg = '{4'b0010, 4'b0100, 4'b0010};
    em = '{2'd0, 2'd1, 2'd2};
    HBUSREQ = 4'b0110;
    HTRANS  = NONSEQ;
    HBURST  = SINGLE;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (HGRANT !== eg[i]) begin
        failures++;
        $display("FAIL rr_grant[%0d] got=%b exp=%b",
                 i, HGRANT, eg[i]);
      end
      checks++;
      if (HMASTER !== em[i]) begin
        failures++;
        $display("FAIL rr_master[%0d] got=%0d exp=%0d",
                 i, HMASTER, em[i]);
      end
    end
  endtask

  task automatic test_burst_hold();
    logic [3:0] exp;
    HBUSREQ = 4'b0100;
    HTRANS  = IDLE;
    tick();
    checks++;
    if (HGRANT !== 4'b0100) begin
      failures++;
      $display("FAIL bh_setup got=%b exp=0100", HGRANT);
    end
    HBUSREQ = 4'b1100;
    HBURST  = INCR8;
    for (int b = 1; b <= 8; b++) begin
      HTRANS = (b == 1) ? NONSEQ : SEQ;
      // master 2 drops its request mid-burst
      if (b >= 4) HBUSREQ = 4'b1000;
      tick();
      exp = (b < 8) ? 4'b0100 : 4'b1000;
      checks++;
      if (HGRANT !== exp) begin
        failures++;
        $display("FAIL bh_beat%0d got=%b exp=%b",
                 b, HGRANT, exp);
      end
    end
    checks++;
    if (HMASTER !== 2'd2) begin
      failures++;
      $display("FAIL bh_master got=%0d exp=2", HMASTER);
    end
  endtask

  task automatic test_wait_states();
    HBUSREQ = 4'b1001;
    HBURST  = INCR4;
    HTRANS  = NONSEQ;
    tick();
    HTRANS  = SEQ;
    tick();
    tick();
    HREADY  = 1'b0;
    for (int w = 0; w < 3; w++) begin
      tick();
      checks++;
      if (HGRANT !== 4'b1000) begin
        failures++;
        $display("FAIL ws_grant[%0d] got=%b exp=1000",
                 w, HGRANT);
      end
      checks++;
      if (HMASTER !== 2'd3) begin
        failures++;
        $display("FAIL ws_master[%0d] got=%0d exp=3",
                 w, HMASTER);
      end
    end
    HREADY = 1'b1;
    tick();
    checks++;
    if (HGRANT !== 4'b0001) begin
      failures++;
      $display("FAIL ws_release got=%b exp=0001", HGRANT);
    end
    HBUSREQ = 4'b0001;
    HTRANS  = IDLE;
    tick();
    checks++;
    if (HMASTER !== 2'd0) begin
      failures++;
      $display("FAIL ws_master_trail got=%0d exp=0", HMASTER);
    end
  endtask

  task automatic test_lock();
    HBUSREQ = 4'b0011;
    HLOCK   = 4'b0010;
    HTRANS  = IDLE;
    tick();
    checks++;
    if (HGRANT !== 4'b0010) begin
      failures++;
      $display("FAIL lk_setup got=%b exp=0010", HGRANT);
    end
    HBURST = INCR4;
    for (int b = 1; b <= 8; b++) begin
      HTRANS = (b == 1 || b == 5) ? NONSEQ : SEQ;
      if (b == 8) HLOCK = 4'b0000;
      tick();
      checks++;
      if (HGRANT !== 4'b0010) begin
        failures++;
        $display("FAIL lk_grant%0d got=%b exp=0010",
                 b, HGRANT);
      end
      checks++;
      if (HMASTLOCK !== (b < 8)) begin
        failures++;
        $display("FAIL lk_mlock%0d got=%b exp=%b",
                 b, HMASTLOCK, (b < 8));
      end
    end
    HTRANS = IDLE;
    tick();
    checks++;
    if (HGRANT !== 4'b0001) begin
      failures++;
      $display("FAIL lk_handover got=%b exp=0001", HGRANT);
    end
  endtask

  task automatic test_retry();
    HBUSREQ = 4'b0011;
    HTRANS  = NONSEQ;
    HBURST  = SINGLE;
    HRESP   = RETRY;
    tick();
    checks++;
    if (HGRANT !== 4'b0001) begin
      failures++;
      $display("FAIL rt_retry got=%b exp=0001", HGRANT);
    end
    HRESP = ERROR;
    tick();
    checks++;
    if (HGRANT !== 4'b0001) begin
      failures++;
      $display("FAIL rt_error got=%b exp=0001", HGRANT);
    end
`ifndef AHB_ARB_SPLIT_EN
    HRESP = SPLIT;
    tick();
    checks++;
    if (HGRANT !== 4'b0001) begin
      failures++;
      $display("FAIL rt_split_as_retry got=%b exp=0001",
               HGRANT);
    end
`endif
    HRESP = OKAY;
    tick();
    checks++;
    if (HGRANT !== 4'b0010) begin
      failures++;
      $display("FAIL rt_okay got=%b exp=0010", HGRANT);
    end
  endtask

  task automatic test_back_to_back();
    HBUSREQ = 4'b0010;
    HBURST  = INCR4;
    for (int b = 1; b <= 8; b++) begin
      HTRANS = (b == 1 || b == 5) ? NONSEQ : SEQ;
      tick();
      checks++;
      if (HGRANT !== 4'b0010) begin
        failures++;
        $display("FAIL b2b_beat%0d got=%b exp=0010",
                 b, HGRANT);
      end
    end
  endtask

  task automatic test_default();
    HBUSREQ = 4'b0000;
    HTRANS  = IDLE;
    tick();
    checks++;
    if (HGRANT !== 4'b0001) begin
      failures++;
      $display("FAIL def_grant got=%b exp=0001", HGRANT);
    end
    checks++;
    if (HMASTER !== 2'd1) begin
      failures++;
      $display("FAIL def_master_prev got=%0d exp=1", HMASTER);
    end
    tick();
    checks++;
    if (HMASTER !== 2'd0) begin
      failures++;
      $display("FAIL def_master got=%0d exp=0", HMASTER);
    end
  endtask

  task automatic test_incr();
    HBUSREQ = 4'b0010;
    HTRANS  = IDLE;
    tick();
    HBUSREQ = 4'b0011;
    HBURST  = INCR;
    HTRANS  = NONSEQ;
    tick();
    checks++;
    if (HGRANT !== 4'b0010) begin
      failures++;
      $display("FAIL incr_first got=%b exp=0010", HGRANT);
    end
    HTRANS = SEQ;
    tick();
    checks++;
    if (HGRANT !== 4'b0010) begin
      failures++;
      $display("FAIL incr_hold got=%b exp=0010", HGRANT);
    end
    HBUSREQ = 4'b0001;
    tick();
    checks++;
    if (HGRANT !== 4'b0001) begin
      failures++;
      $display("FAIL incr_end got=%b exp=0001", HGRANT);
    end
  endtask

`ifdef AHB_ARB_SPLIT_EN
  task automatic test_split();
    HBUSREQ = 4'b1000;
    HBURST  = SINGLE;
    HTRANS  = IDLE;
    tick();
    checks++;
    if (HGRANT !== 4'b1000) begin
      failures++;
      $display("FAIL sp_setup got=%b exp=1000", HGRANT);
    end
    HBUSREQ = 4'b1001;
    HTRANS  = NONSEQ;
    HRESP   = SPLIT;
    tick();
    checks++;
    if (HGRANT !== 4'b0001) begin
      failures++;
      $display("FAIL sp_force got=%b exp=0001", HGRANT);
    end
    HRESP   = OKAY;
    HBUSREQ = 4'b1000;
    HTRANS  = IDLE;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (HGRANT !== 4'b0001) begin
        failures++;
        $display("FAIL sp_masked[%0d] got=%b exp=0001",
                 i, HGRANT);
      end
    end
    HSPLIT = 4'b1000;
    tick();
    HSPLIT = 4'b0000;
    checks++;
    if (HGRANT !== 4'b1000) begin
      failures++;
      $display("FAIL sp_resume got=%b exp=1000", HGRANT);
    end
  endtask
`endif

  task automatic test_reset_mid();
    HBUSREQ = 4'b0100;
    HLOCK   = 4'b0100;
    HTRANS  = IDLE;
    tick();
    HBURST  = INCR4;
    HTRANS  = NONSEQ;
    tick();
    checks++;
    if (HMASTLOCK !== 1'b1) begin
      failures++;
      $display("FAIL rm_locked got=%b exp=1", HMASTLOCK);
    end
    HTRANS = SEQ;
    tick();
    #2;
    HRESETn = 1'b0;
    #1;
    checks++;
    if (HGRANT !== 4'b0001) begin
      failures++;
      $display("FAIL rm_grant got=%b exp=0001", HGRANT);
    end
    checks++;
    if (HMASTER !== 2'd0 || HMASTLOCK !== 1'b0) begin
      failures++;
      $display("FAIL rm_master got=%0d/%b exp=0/0",
               HMASTER, HMASTLOCK);
    end
    tick();
    HRESETn = 1'b1;
    HLOCK   = 4'b0000;
    HBUSREQ = 4'b1100;
    HTRANS  = IDLE;
    tick();
    checks++;
    if (HGRANT !== 4'b0100) begin
      failures++;
      $display("FAIL rm_ptr got=%b exp=0100", HGRANT);
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_burst_hold();
    test_wait_states();
    test_lock();
    test_retry();
    test_back_to_back();
    test_default();
    test_incr();
`ifdef AHB_ARB_SPLIT_EN
    test_split();
`endif
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
